uart_tx_buffered: RTL and testbench
===================================

# uart_tx_buffered

Serial transmit stage directly downstream of the command-line monitor. It accepts bytes over the monitor's `send_data` / `data_avail` / `send_strobe` handshake and queues them in a small FIFO. It then shifts them out LSB-first as asynchronous serial frames on the host `tx` pin. Queuing lets the monitor's "OK", "ERR" and hex-dump traffic proceed without stalling per bit.

## Interface
- `CLKS_PER_BIT`, 104, system clocks per serial bit (12 MHz / 115200); legal values are ≥ 4.
- `FIFO_DEPTH`, 16, byte entries; must be a power of two, ≥ 2.
- `clock`  in  1  system clock. Single clock domain: everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `send_data`  in  8  byte from the monitor; valid whenever `data_avail` = 1.
- `data_avail`  in  1  monitor offers `send_data`.
- `send_strobe`  out  1  1 = ready for a byte; a one-cycle low pulse acknowledges a captured byte; held low while the FIFO is full.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is on the line or the FIFO is non-empty.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of queued bytes.

## Operation
- Reset values: `send_strobe` = 1, `tx` = 1, `busy` = 0, `fifo_level` = 0, FSM in IDLE, pointers = 0, `armed` = 1.
- **Capture**
  - A byte is captured when `data_avail` = 1, `armed` = 1 and the FIFO is not full.
  - On capture, `send_data` is pushed and `armed` is cleared.
  - `armed` is set again only in a cycle where `data_avail` = 0.
  - This guarantees one push per offer, even though the monitor holds `data_avail` high for a cycle after `send_strobe` returns high.
- **`send_strobe` register:** next value is `!(capture) && !(full after this cycle's push/pop)`.
- **FIFO**
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - A simultaneous push and pop is legal at any level, including 0 (byte bypasses storage) and full (the pop frees the slot). `fifo_level` is unchanged in that case.
  - A push is never accepted while full. A pop is never issued while empty.
- **Transmit FSM:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: if the FIFO is non-empty, pop into `shreg` and go to START. Otherwise `tx` = 1.
  - START: `tx` = 0 for one bit time.
  - DATA: `tx` = `shreg[0]`; shift right each bit. The 3-bit bit counter runs 0..7, then exits.
  - STOP: `tx` = 1 for one bit time. Then go back to IDLE, which may pop again in the same cycle the stop bit ends, so frames are back-to-back.
- **Baud counter:** loads `CLKS_PER_BIT-1` on each state entry and decrements. The bit ends when it reads 0.
- **Reset mid-frame:** `tx` returns to 1 on the next edge. FIFO contents are discarded. The truncated frame is not retransmitted.

## Timing
- Capture in cycle N → `send_strobe` is low in cycle N+1 only (unless full), and high again in N+2.
- The byte is visible to IDLE in N+1. The start bit begins on `tx` in N+2 if the FSM was idle and the FIFO was empty.
- Each bit lasts exactly `CLKS_PER_BIT` clocks.
- A frame lasts 10 × `CLKS_PER_BIT` clocks (11 with parity).
- `busy` falls in the cycle after the last stop bit ends with an empty FIFO.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity, the XOR of the 8 data bits, for one bit time.
  - Frame format is 8E1.
- `UART_TX_PARITY_EN` undefined: no PARITY state, and the frame format is 8N1.
- The macro changes nothing else: handshake and FIFO behaviour are identical.

## Structure
- The shared package `uart_pkg` holds:
  - the FSM state encodings (`TX_IDLE`, `TX_START`, `TX_DATA`, `TX_PARITY`, `TX_STOP`);
  - the default `CLKS_PER_BIT` constant.
- Sub-module `uart_tx_fifo`: synchronous single-clock FIFO with push, pop, full, empty and level outputs, parameterised by `FIFO_DEPTH`.
- The top level holds the capture/arming logic, the `send_strobe` register, the baud counter and the FSM.

## Test plan
- **Single byte:** reset, then hold `data_avail` for 3 cycles with `send_data` = 0x4F.
  - Exactly one push, and one low cycle on `send_strobe`.
  - `tx` shows 0, then 1,1,1,1,0,0,1,0, then 1; each bit lasts `CLKS_PER_BIT` clocks.
- **Monitor handshake replay:** the "OK\r\n" sequence using the monitor's strobing/wait_xmit protocol.
  - Four frames are sent back-to-back with no idle gap.
  - `fifo_level` peaks at 3 or fewer.
- **Fill:** 17 offers with `FIFO_DEPTH` = 16 while the line is busy.
  - `send_strobe` stays low once 16 are queued (one of them has already been popped into the frame).
  - It rises after the next pop, and no byte is lost or duplicated.
- **Simultaneous push and pop:** capture in the same cycle as an IDLE pop at level 1.
  - Level stays 1, and transmit order is preserved.
- **Reset at bit 4 of 0xA5:**
  - `tx` = 1 on the next edge, `fifo_level` = 0, `send_strobe` = 1.
  - No further frame follows.
- **Parity (`UART_TX_PARITY_EN`):** send 0x07.
  - The parity bit is 1, and the frame is 11 bit times.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state
// encodings and the default bit period (12 MHz system clock, 115200 baud).
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 104;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  // Even parity bit of a byte (1 when the byte holds an odd number of ones).
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake between the command-line monitor (master) and the
// buffered UART transmitter (slave).
interface uart_tx_buffered_if;
  logic [7:0] send_data;
  logic       data_avail;
  logic       send_strobe;

  modport master (output send_data, output data_avail, input send_strobe);
  modport slave  (input send_data, input data_avail, output send_strobe);
endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO. A push and a pop in the same cycle are accepted at
// any level: when empty the written byte is forwarded straight to rd_data,
// when full the pop frees the slot the push reuses.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic [7:0]                    wr_data,
  input  logic                          pop,
  output logic [7:0]                    rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && (!empty || push);
  assign rd_data = empty ? wr_data : mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered asynchronous serial transmitter fed by the monitor handshake.
// Bytes are queued in uart_tx_fifo and sent LSB-first, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  uart_tx_buffered_if.slave           mon,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  logic          capture;
  logic          armed;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rd_data;
  logic [LW-1:0] level_next;

  tx_state_t     state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [7:0]    shreg, shreg_next;
  logic          tx_next;
`ifdef UART_TX_PARITY_EN
  logic          par, par_next;
`endif

  // One push per offer: armed drops on capture and returns only once the
  // monitor has withdrawn data_avail.
  assign capture    = mon.data_avail && armed && !fifo_full;
  assign level_next = fifo_level + LW'(capture) - LW'(pop);
  assign busy       = (state != TX_IDLE) || !fifo_empty;

  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (capture),
    .wr_data (mon.send_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Next-state, baud/bit counters, shifter and line level.
  always_comb begin
    state_next   = state;
    baud_next    = (baud == '0) ? baud : baud - 1'b1;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    pop          = 1'b0;
    tx_next      = 1'b1;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shreg_next = fifo_rd_data;
          state_next = TX_START;
          baud_next  = BAUD_LOAD;
        end
      end
      TX_START: begin
        if (baud == '0) begin
          state_next   = TX_DATA;
          baud_next    = BAUD_LOAD;
          bit_cnt_next = 3'd0;
        end
      end
      TX_DATA: begin
        if (baud == '0) begin
          baud_next = BAUD_LOAD;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = TX_PARITY;
`else
            state_next = TX_STOP;
`endif
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
            shreg_next   = shreg >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (baud == '0) begin
          state_next = TX_STOP;
          baud_next  = BAUD_LOAD;
        end
      end
`endif
      TX_STOP: begin
        // End of stop bit doubles as the IDLE decision so frames abut.
        if (baud == '0) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            shreg_next = fifo_rd_data;
            state_next = TX_START;
            baud_next  = BAUD_LOAD;
          end else begin
            state_next = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    par_next = pop ? even_parity(fifo_rd_data) : par;
`endif
    case (state_next)
      TX_START:  tx_next = 1'b0;
      TX_DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_next = par_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

  // Control registers: FSM, counters, registered line, handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= TX_IDLE;
      baud        <= '0;
      bit_cnt     <= '0;
      tx          <= 1'b1;
      armed       <= 1'b1;
      mon.send_strobe <= 1'b1;
    end else begin
      state       <= state_next;
      baud        <= baud_next;
      bit_cnt     <= bit_cnt_next;
      tx          <= tx_next;
      if (capture)              armed <= 1'b0;
      else if (!mon.data_avail) armed <= 1'b1;
      mon.send_strobe <= !capture && (level_next != LW'(FIFO_DEPTH));
    end
  end

  // Data registers: shifter (and parity bit), no reset needed.
  always_ff @(posedge clock) begin
    shreg <= shreg_next;
`ifdef UART_TX_PARITY_EN
    par   <= par_next;
`endif
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: table of bytes with hand-written
// expected frames, plus sequences for handshake replay, fill, push/pop
// overlap, mid-frame reset and frame length.
module tb_uart_tx_buffered;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int LW    = 5;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic          clock = 1'b0;
  logic          reset;
  logic          tx;
  logic          busy;
  logic [LW-1:0] fifo_level;

  uart_tx_buffered_if mon();

  uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .mon        (mon),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  int rst_cnt = 0;
  always @(posedge clock) if (reset) rst_cnt <= rst_cnt + 1;

  // frame layout: [0] start, [8:1] data, [9] parity, [10] stop
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t vecs[6];

  logic [10:0] rx_q[$];
  int          rx_starts[$];
  int n_cmp = 0, n_fail = 0;
  int lvl_peak = 0, strobe_lows = 0;

  // Serial receiver: samples mid-bit, drops frames cut by a reset.
  initial begin
    forever begin
      @(negedge clock);
      if (reset !== 1'b1 && tx === 1'b0) begin
        int r0;
        logic [10:0] f;
        r0 = rst_cnt;
        f  = '0;
        rx_starts.push_back(cyc);
        for (int k = 0; k < NB; k++) begin
          repeat ((k == 0) ? CPB / 2 : CPB) @(negedge clock);
          if (k < 9)           f[k]  = tx;
          else if (k == NB-1)  f[10] = tx;
          else                 f[9]  = tx;
        end
        if (rst_cnt == r0) rx_q.push_back(f);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (int'(fifo_level) > lvl_peak) lvl_peak = int'(fifo_level);
    if (mon.send_strobe === 1'b0) strobe_lows++;
  endtask

  function automatic logic frame_bit(input logic [10:0] f, input int b);
    if (b < 9)       return f[b];
    if (b == NB - 1) return f[10];
    return f[9];
  endfunction

  task automatic offer(input logic [7:0] b, input bit hold_after);
    int t;
    t = 0;
    while (mon.send_strobe !== 1'b1 && t < 4 * FRAME) begin tick(); t++; end
    check("offer_ready", int'(mon.send_strobe), 1);
    mon.send_data  = b;
    mon.data_avail = 1'b1;
    t = 0;
    do begin tick(); t++; end while (mon.send_strobe !== 1'b0 && t < 8);
    check("offer_ack", int'(mon.send_strobe), 0);
    if (hold_after) begin
      t = 0;
      while (mon.send_strobe !== 1'b1 && t < 4 * FRAME) begin tick(); t++; end
      tick();
    end
    mon.data_avail = 1'b0;
    tick();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin tick(); t++; end
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic wait_start(input int sbase, output int s);
    int t;
    t = 0;
    while (rx_starts.size() <= sbase && t < 4 * FRAME) begin tick(); t++; end
    check("frame_started", int'(rx_starts.size() > sbase), 1);
    s = (rx_starts.size() > sbase) ? rx_starts[sbase] : cyc;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 40 * FRAME) begin tick(); t++; end
    repeat (CPB) tick();
  endtask

  initial begin
    int errs, base, sbase, s, t, highs;
    int exp_b;
    vecs[0] = '{8'h4F, 11'b1_1_01001111_0};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[3] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[4] = '{8'h07, 11'b1_1_00000111_0};
    vecs[5] = '{8'h80, 11'b1_1_10000000_0};

    reset = 1'b1;
    mon.data_avail = 1'b0;
    mon.send_data  = 8'h00;
    repeat (3) tick();
    check("rst_tx", int'(tx), 1);
    check("rst_strobe", int'(mon.send_strobe), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(fifo_level), 0);
    reset = 1'b0;
    repeat (2) tick();

    // Single byte, data_avail held three cycles
    rx_q.delete();
    base = strobe_lows;
    mon.send_data  = 8'h4F;
    mon.data_avail = 1'b1;
    tick();
    check("cap_strobe_low", int'(mon.send_strobe), 0);
    check("cap_level", int'(fifo_level), 1);
    check("cap_tx_still_idle", int'(tx), 1);
    tick();
    check("cap_strobe_high", int'(mon.send_strobe), 1);
    errs = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) tick();
      if (k == 1) mon.data_avail = 1'b0;
      if (tx !== frame_bit(vecs[0].frame, k / CPB)) errs++;
      if (k == FRAME - 1) check("busy_last_stop", int'(busy), 1);
    end
    check("wave_4F_errs", errs, 0);
    tick();
    check("busy_fall", int'(busy), 0);
    check("idle_tx", int'(tx), 1);
    check("strobe_low_cycles", strobe_lows - base, 1);
    repeat (4) tick();
    check("single_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("single_rx_data", int'(rx_q[0][8:1]), 'h4F);

    // Table-driven frames
    for (int i = 0; i < 6; i++) begin
      rx_q.delete();
      offer(vecs[i].data, 1'b1);
      wait_rx(1, 2 * FRAME);
      if (rx_q.size() > 0) begin
        check("tbl_start", int'(rx_q[0][0]), int'(vecs[i].frame[0]));
        check("tbl_data", int'(rx_q[0][8:1]), int'(vecs[i].frame[8:1]));
        check("tbl_stop", int'(rx_q[0][10]), int'(vecs[i].frame[10]));
`ifdef UART_TX_PARITY_EN
        check("tbl_parity", int'(rx_q[0][9]), int'(vecs[i].frame[9]));
`endif
      end
      wait_idle();
    end

    // "OK\r\n" replay with the wait_xmit protocol
    rx_q.delete();
    sbase = rx_starts.size();
    lvl_peak = 0;
    offer(8'h4F, 1'b1);
    offer(8'h4B, 1'b1);
    offer(8'h0D, 1'b1);
    offer(8'h0A, 1'b1);
    wait_rx(4, 6 * FRAME);
    if (rx_q.size() == 4) begin
      check("ok_b0", int'(rx_q[0][8:1]), 'h4F);
      check("ok_b1", int'(rx_q[1][8:1]), 'h4B);
      check("ok_b2", int'(rx_q[2][8:1]), 'h0D);
      check("ok_b3", int'(rx_q[3][8:1]), 'h0A);
    end
    if (rx_starts.size() >= sbase + 4)
      for (int j = 1; j < 4; j++)
        check("ok_gap", rx_starts[sbase+j] - rx_starts[sbase+j-1], FRAME);
    check("ok_peak_le3", int'(lvl_peak <= 3), 1);
    wait_idle();

    // Push and pop in the same cycle at level 1
    rx_q.delete();
    sbase = rx_starts.size();
    offer(8'h11, 1'b0);
    offer(8'h22, 1'b0);
    wait_start(sbase, s);
    check("pp_level_before", int'(fifo_level), 1);
    t = 0;
    while (cyc < s + FRAME - 1 && t < 2 * FRAME) begin tick(); t++; end
    mon.send_data  = 8'h33;
    mon.data_avail = 1'b1;
    tick();
    check("pp_level", int'(fifo_level), 1);
    check("pp_ack", int'(mon.send_strobe), 0);
    mon.data_avail = 1'b0;
    wait_rx(3, 4 * FRAME);
    if (rx_q.size() == 3) begin
      check("pp_b0", int'(rx_q[0][8:1]), 'h11);
      check("pp_b1", int'(rx_q[1][8:1]), 'h22);
      check("pp_b2", int'(rx_q[2][8:1]), 'h33);
    end
    if (rx_starts.size() >= sbase + 3)
      check("pp_gap", rx_starts[sbase+2] - rx_starts[sbase+1], FRAME);
    wait_idle();

    // Fill: 17 offers while the first frame is on the line
    rx_q.delete();
    for (int i = 0; i < 17; i++) offer(8'h40 + 8'(i), 1'b0);
    check("full_level", int'(fifo_level), 16);
    check("full_strobe", int'(mon.send_strobe), 0);
    highs = 0;
    repeat (20) begin tick(); if (mon.send_strobe === 1'b1) highs++; end
    check("full_strobe_held", highs, 0);
    t = 0;
    while (mon.send_strobe !== 1'b1 && t < 2 * FRAME) begin tick(); t++; end
    check("full_release", int'(mon.send_strobe), 1);
    check("full_release_level", int'(fifo_level), 15);
    offer(8'h51, 1'b0);
    wait_rx(18, 20 * FRAME);
    errs = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      exp_b = (i < 17) ? ('h40 + i) : 'h51;
      if (int'(rx_q[i][8:1]) != exp_b) errs++;
    end
    check("fill_order_errs", errs, 0);
    wait_idle();

    // Reset at data bit 4 of 0xA5 with a second byte queued
    rx_q.delete();
    sbase = rx_starts.size();
    offer(8'hA5, 1'b0);
    offer(8'h3C, 1'b0);
    wait_start(sbase, s);
    t = 0;
    while (cyc < s + 5 * CPB + CPB / 2 && t < 2 * FRAME) begin tick(); t++; end
    check("rst_mid_tx_before", int'(tx), 0);
    reset = 1'b1;
    tick();
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_level", int'(fifo_level), 0);
    check("rst_mid_strobe", int'(mon.send_strobe), 1);
    check("rst_mid_busy", int'(busy), 0);
    reset = 1'b0;
    sbase = rx_starts.size();
    repeat (3 * FRAME) tick();
    check("rst_no_new_frame", rx_starts.size(), sbase);
    check("rst_no_rx", rx_q.size(), 0);
    check("rst_tx_idle", int'(tx), 1);

    // Frame length and parity on 0x07
    rx_q.delete();
    sbase = rx_starts.size();
    offer(8'h07, 1'b0);
    wait_start(sbase, s);
    t = 0;
    while (busy !== 1'b0 && t < 2 * FRAME) begin tick(); t++; end
    check("frame_len", cyc - s, FRAME);
    wait_rx(1, FRAME);
    if (rx_q.size() > 0) begin
      check("p07_data", int'(rx_q[0][8:1]), 'h07);
      check("p07_stop", int'(rx_q[0][10]), 1);
`ifdef UART_TX_PARITY_EN
      check("p07_parity", int'(rx_q[0][9]), 1);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
